// File: rtl/iic_pkg.sv
// -----------------------------------------------------------------------------
// iic_pkg
// Shared definitions for the codec configuration sequencer:
//   - seq_state_e        : sequencer FSM state encoding
//   - DEFAULT_SLAVE_ADDR : audio codec 8-bit write address
//   - SET_LIN_L..SET_ACTIVE : codec register table indices, used by the
//                          external ROM that feeds Lut_Data
// -----------------------------------------------------------------------------
package iic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT_LOW,
        ST_WAIT_HIGH,
        ST_CHECK,
        ST_GAP,
        ST_DONE,
        ST_FAIL
    } seq_state_e;

    localparam logic [7:0] DEFAULT_SLAVE_ADDR = 8'h34;

    // Table positions of the codec init words.
    localparam int SET_LIN_L   = 0;
    localparam int SET_LIN_R   = 1;
    localparam int SET_HEAD_L  = 2;
    localparam int SET_HEAD_R  = 3;
    localparam int A_PATH_CTRL = 4;
    localparam int D_PATH_CTRL = 5;
    localparam int POWER_ON    = 6;
    localparam int SET_FORMAT  = 7;
    localparam int SAMPLE_CTRL = 8;
    localparam int SET_ACTIVE  = 9;

endpackage

// File: rtl/iic_config_sequencer_if.sv
// -----------------------------------------------------------------------------
// iic_config_sequencer_if
// Handshake between the sequencer and the I2C byte-write engine.
//   IIC_Data [23:0] : {slave addr, reg word} to transmit
//   IIC_Go          : level request, high for the whole transaction
//   IIC_End         : engine idle/finished flag (high = idle)
//   IIC_Ack         : high = at least one NACK in the last transaction
// master = sequencer side, slave = engine side.
// -----------------------------------------------------------------------------
interface iic_config_sequencer_if;

    logic [23:0] IIC_Data;
    logic        IIC_Go;
    logic        IIC_End;
    logic        IIC_Ack;

    modport master (
        output IIC_Data,
        output IIC_Go,
        input  IIC_End,
        input  IIC_Ack
    );

    modport slave (
        input  IIC_Data,
        input  IIC_Go,
        output IIC_End,
        output IIC_Ack
    );

endinterface

// File: rtl/iic_sync2.sv
// -----------------------------------------------------------------------------
// iic_sync2
// Two-flop synchronizer for a single level signal crossing from the I2C clock
// domain. Adds two clk cycles of latency to every edge.
//   clk       : destination clock
//   rst       : asynchronous, active-high reset
//   d         : asynchronous input
//   q         : synchronized output (RESET_VAL while in reset)
// -----------------------------------------------------------------------------
module iic_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its source; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/iic_config_sequencer.sv
// -----------------------------------------------------------------------------
// iic_config_sequencer
// Walks a table of 16-bit codec register words (external combinational ROM)
// and issues each as a 24-bit I2C write through the I2C byte-write engine,
// with NACK retry, hung-engine timeout and an inter-transaction gap.
//   Clk_In      : system clock
//   Reset       : asynchronous, active-high reset
//   Start       : one-cycle request to run the table (IDLE/DONE/FAIL only)
//   Lut_Index   : table address to the ROM
//   Lut_Data    : ROM word {reg_addr[6:0], data[8:0]} for Lut_Index
//   iic         : engine handshake (master side)
//   Busy        : high from Start acceptance until DONE or FAIL
//   Done/Error  : sticky completion / failure flags, cleared by Start
//   Fail_Index  : entry that failed, valid while Error=1
// -----------------------------------------------------------------------------
module iic_config_sequencer
    import iic_pkg::*;
#(
    parameter int          LUT_SIZE       = 11,
    parameter int          IDX_W          = 6,
    parameter logic [7:0]  SLAVE_ADDR     = DEFAULT_SLAVE_ADDR,
    parameter int          MAX_RETRY      = 3,
    parameter int          GAP_CYCLES     = 16,
    parameter int          TIMEOUT_CYCLES = 2000000
) (
    input  logic                 Clk_In,
    input  logic                 Reset,
    input  logic                 Start,
    output logic [IDX_W-1:0]     Lut_Index,
    input  logic [15:0]          Lut_Data,
    iic_config_sequencer_if.master iic,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Error,
    output logic [IDX_W-1:0]     Fail_Index
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);

    // End idles high, Ack idles low; the sync flops reset to those levels so
    // nothing spurious is seen coming out of reset.
    logic end_s;
    logic ack_s;

    iic_sync2 #(.RESET_VAL(1'b1)) u_sync_end (
        .clk (Clk_In),
        .rst (Reset),
        .d   (iic.IIC_End),
        .q   (end_s)
    );

    iic_sync2 #(.RESET_VAL(1'b0)) u_sync_ack (
        .clk (Clk_In),
        .rst (Reset),
        .d   (iic.IIC_Ack),
        .q   (ack_s)
    );

    seq_state_e          state_q,      state_d;
    logic [IDX_W-1:0]    lut_index_q,  lut_index_d;
    logic [23:0]         iic_data_q,   iic_data_d;
    logic                iic_go_q,     iic_go_d;
    logic                busy_q,       busy_d;
    logic                done_q,       done_d;
    logic                error_q,      error_d;
    logic [IDX_W-1:0]    fail_index_q, fail_index_d;
    logic [RETRY_W-1:0]  retry_q,      retry_d;
    logic                nack_q,       nack_d;
    logic [TIMER_W-1:0]  timer_q,      timer_d;
    logic [GAP_W-1:0]    gap_q,        gap_d;

    logic [TIMER_W-1:0]  timer_inc;
    logic                timeout_hit;
    logic                fail_now;

    // Saturating timer; it is compared against TIMEOUT_CYCLES-1 so the
    // TIMEOUT_CYCLES-th waiting cycle is the one that gives up.
    assign timer_inc   = (timer_q == {TIMER_W{1'b1}}) ? timer_q : timer_q + TIMER_W'(1);
    assign timeout_hit = (timer_q >= TIMER_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every signal assigned here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d      = state_q;
        lut_index_d  = lut_index_q;
        iic_data_d   = iic_data_q;
        iic_go_d     = iic_go_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        fail_index_d = fail_index_q;
        retry_d      = retry_q;
        nack_d       = nack_q;
        timer_d      = timer_q;
        gap_d        = gap_q;
        fail_now     = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (Start) begin
                    lut_index_d = '0;
                    retry_d     = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = ST_LOAD;
                end
            end

            ST_LOAD: begin
                iic_data_d = {SLAVE_ADDR, Lut_Data};
                state_d    = ST_ISSUE;
            end

            ST_ISSUE: begin
                iic_go_d = 1'b1;
                timer_d  = '0;
                state_d  = ST_WAIT_LOW;
            end

            // End is still high from the previous idle period; only a low
            // End proves the engine has accepted this request.
            ST_WAIT_LOW: begin
                if (!end_s) begin
                    timer_d = '0;
                    state_d = ST_WAIT_HIGH;
                end else if (timeout_hit) begin
                    fail_now = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end

            ST_WAIT_HIGH: begin
                if (end_s) begin
                    nack_d   = ack_s;
                    iic_go_d = 1'b0;
                    state_d  = ST_CHECK;
                end else if (timeout_hit) begin
                    fail_now = 1'b1;
                end else begin
                    timer_d = timer_inc;
                end
            end

            // nack_q stays valid through GAP and tells it whether to replay
            // the same entry; an exhausted retry budget never reaches GAP.
            ST_CHECK: begin
                gap_d = '0;
                if (!nack_q) begin
                    retry_d = '0;
                    state_d = ST_GAP;
                end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
                    retry_d = retry_q + RETRY_W'(1);
                    state_d = ST_GAP;
                end else begin
                    fail_now = 1'b1;
                end
            end

            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (nack_q) begin
                        state_d = ST_LOAD;
                    end else if (lut_index_q == IDX_W'(LUT_SIZE - 1)) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        lut_index_d = lut_index_q + IDX_W'(1);
                        state_d     = ST_LOAD;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (fail_now) begin
            iic_go_d     = 1'b0;
            busy_d       = 1'b0;
            error_d      = 1'b1;
            fail_index_d = lut_index_q;
            state_d      = ST_FAIL;
        end
    end

    always_ff @(posedge Clk_In or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            lut_index_q  <= '0;
            iic_data_q   <= '0;
            iic_go_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fail_index_q <= '0;
            retry_q      <= '0;
            nack_q       <= 1'b0;
            timer_q      <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            lut_index_q  <= lut_index_d;
            iic_data_q   <= iic_data_d;
            iic_go_q     <= iic_go_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            fail_index_q <= fail_index_d;
            retry_q      <= retry_d;
            nack_q       <= nack_d;
            timer_q      <= timer_d;
            gap_q        <= gap_d;
        end
    end

    assign Lut_Index    = lut_index_q;
    assign iic.IIC_Data = iic_data_q;
    assign iic.IIC_Go   = iic_go_q;
    assign Busy         = busy_q;
    assign Done         = done_q;
    assign Error        = error_q;
    assign Fail_Index   = fail_index_q;

endmodule

// File: doc/iic_config_sequencer.md
Name: iic_config_sequencer

Overview:
- Walks a table of 16-bit codec register words and issues each as a 24-bit I2C write through the existing I2C byte-write engine, using its Go/End/Ack handshake.
- Sits between the Avalon/CPU side, which pulses Start or ties it to power-on, and the I2C engine.
- Replaces the CPU-driven single-transaction path for the audio codec init sequence.
- Adds NACK retry, a hung-engine timeout, and an inter-transaction gap.

Parameters:
- LUT_SIZE, 11: number of table entries; indices 0..LUT_SIZE-1.
- IDX_W, 6: width of Lut_Index; LUT_SIZE must be ≤ 2**IDX_W.
- SLAVE_ADDR, 8'h34: device write address, placed in IIC_Data[23:16].
- MAX_RETRY, 3: extra attempts per entry after a NACK; 0 means no retry.
- GAP_CYCLES, 16: idle Clk_In cycles between transactions; must be ≥ 1.
- TIMEOUT_CYCLES, 2000000: maximum Clk_In cycles to wait for either End edge.

Ports:
- Clk_In  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  single-cycle request to run the whole table; ignored unless in IDLE, DONE or FAIL.
- Lut_Index  out  IDX_W  table address, driven to a combinational ROM.
- Lut_Data  in  16  {reg_addr[6:0], data[8:0]} for the current Lut_Index, valid in the same cycle.
- IIC_Data  out  24  {SLAVE_ADDR, Lut_Data latched}, to the engine.
- IIC_Go  out  1  level; held high for the whole transaction.
- IIC_End  in  1  engine idle/finished flag; high when idle, low while busy.
- IIC_Ack  in  1  high means at least one NACK in the last transaction.
- Busy  out  1  high from Start acceptance until DONE or FAIL.
- Done  out  1  sticky; set in DONE, cleared on Start or Reset.
- Error  out  1  sticky; set in FAIL, cleared on Start or Reset.
- Fail_Index  out  IDX_W  entry that failed; valid while Error=1.

Behaviour:
- Reset values: state IDLE; Lut_Index 0; IIC_Data 0; IIC_Go 0; Busy 0; Done 0; Error 0; Fail_Index 0; all counters 0.
- FSM states: IDLE, LOAD, ISSUE, WAIT_LOW, WAIT_HIGH, CHECK, GAP, DONE, FAIL.
- IDLE/DONE/FAIL + Start:
  - Lut_Index←0, retry←0, Done←0, Error←0, Busy←1.
  - Go to LOAD.
- LOAD (1 cycle): IIC_Data←{SLAVE_ADDR, Lut_Data}, then ISSUE.
- ISSUE (1 cycle): IIC_Go←1, timer←0, then WAIT_LOW.
- WAIT_LOW: wait for IIC_End=0.
  - The engine's End is high at idle, so a high End at this point is stale and must not be taken as completion.
  - timer reaching TIMEOUT_CYCLES → FAIL.
- WAIT_HIGH: on the first cycle with IIC_End=1, sample IIC_Ack into nack_r, IIC_Go←0, then CHECK.
  - timer restarts on entry; timeout → FAIL with IIC_Go←0.
- CHECK:
  - nack_r=0: retry←0, go to GAP.
  - nack_r=1 and retry<MAX_RETRY: retry+1, go to GAP, then re-run the same index.
  - nack_r=1 and retry=MAX_RETRY: FAIL.
- GAP: hold IIC_Go=0 for GAP_CYCLES cycles; the engine restarts its bit counter while Go is low. Then:
  - retrying: go to LOAD with the same index.
  - else if Lut_Index=LUT_SIZE-1: go to DONE.
  - else: Lut_Index+1, go to LOAD.
- DONE: Busy←0, Done←1.
- FAIL: Busy←0, Error←1, Fail_Index←Lut_Index, IIC_Go←0.
- Start while Busy: ignored, with no restart or effect.
- Start coinciding with the transition into DONE or FAIL: ignored in that cycle.
- Reset mid-transaction: IIC_Go drops immediately. The engine self-recovers because it restarts when Go is low.
- IIC_End and IIC_Ack come from the slower I2C clock domain. Each passes through a 2-flop synchronizer before any use, which adds 2 cycles of latency to every edge.
- Timer width is clog2(TIMEOUT_CYCLES+1) and saturates at its maximum.
- retry width is clog2(MAX_RETRY+1).

Decomposition:
- Shared package iic_pkg holds:
  - FSM state enum.
  - Codec register index constants (SET_LIN_L … SET_ACTIVE).
  - Default SLAVE_ADDR.
- Sub-module iic_sync2: 2-flop synchronizer with asynchronous active-high reset.
  - Reset value 1 for End, 0 for Ack.
  - Instantiated twice.
- The ROM lives outside this block.

Test Plan:
- Happy path:
  - Stimulus: LUT_SIZE=3; Lut_Data entries 16'h001A, 16'h021A, 16'h0C00; engine model responds with End low 5 cycles, then high, Ack=0.
  - Required: IIC_Data sequence 24'h34001A, 24'h34021A, 24'h340C00; Done=1, Busy=0, Error=0.
- Single NACK:
  - Stimulus: entry 1 NACKs once.
  - Required: 24'h34021A issued twice; final Done=1; 4 IIC_Go rising edges total.
- Persistent NACK:
  - Stimulus: MAX_RETRY=2; entry 2 always NACKs.
  - Required: entry 2 attempted 3 times; Error=1, Fail_Index=2, IIC_Go=0, Done=0.
- Hung engine:
  - Stimulus: End stays high after Go with TIMEOUT_CYCLES=100.
  - Required: FAIL 100 (+2 sync) cycles after ISSUE; Error=1, Fail_Index=0.
- Reset mid-transaction:
  - Stimulus: assert Reset in WAIT_HIGH of entry 1.
  - Required: IIC_Go=0, Busy=0, Lut_Index=0 asynchronously; a following Start replays from entry 0.
- Start while Busy and re-arm:
  - Stimulus: pulse Start while Busy; later pulse Start after DONE.
  - Required: no change while Busy; after DONE, Done clears and the sequence reruns.
